// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesting blocks and rr_arbiter8.
//   req         : per-requester level request (driven by requesters)
//   grant       : one-hot grant, or zero
//   grant_idx   : binary index of the holder, 0 when idle
//   grant_valid : any grant bit set
//   timeout     : one-cycle pulse when a hold is forcibly revoked
// master = requester side, slave = arbiter side.
interface rr_arbiter8_if;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  modport master (output req, input grant, grant_idx, grant_valid, timeout);
  modport slave  (input req, output grant, grant_idx, grant_valid, timeout);
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter for a shared 3-to-8 decoded resource.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   arb : rr_arbiter8_if.slave (req in; grant/grant_idx/grant_valid/timeout out)
// All outputs are registered. A holder keeps the grant while its req stays
// high; on release the next requester in rotation order from ptr takes over
// at the same edge.
// Optional feature: define ARB_TIMEOUT_EN to cap a hold at HOLD_MAX cycles.
module rr_arbiter8 #(
  parameter int HOLD_MAX = 15
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter8_if.slave  arb
);
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("rr_arbiter8: HOLD_MAX must be in 1..255");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] ptr_q, ptr_d;
  logic       valid_q, valid_d;
  logic       to_q, to_d;

  // One scanner serves every case: masking the current holder out makes it
  // last in priority on release (its req is 0 anyway) and excluded on timeout.
  logic [7:0] scan_req;
  logic       win_found;
  logic [2:0] win_idx;
  logic [2:0] cand;

  assign scan_req = arb.req & ~grant_q;

  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    cand      = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);  // 3-bit add wraps 7 -> 0
      if (!win_found && scan_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] hold_q, hold_d;
`endif

  logic take, drop;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    to_d    = 1'b0;
    take    = 1'b0;
    drop    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      IDLE: take = win_found;
      GRANT: begin
        if (!arb.req[idx_q]) begin
          take = win_found;
          drop = !win_found;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == HOLD_LAST) begin
          // Hold limit hit: hand off if anyone else waits, else the holder
          // keeps it with a fresh count. The pulse fires either way.
          to_d   = 1'b1;
          take   = win_found;
          hold_d = 8'd0;
        end else begin
          hold_d = hold_q + 8'd1;
        end
`endif
      end
      default: drop = 1'b1;
    endcase

    if (take) begin
      state_d = GRANT;
      grant_d = 8'd1 << win_idx;
      idx_d   = win_idx;
      valid_d = 1'b1;
      ptr_d   = win_idx + 3'd1;
`ifdef ARB_TIMEOUT_EN
      hold_d  = 8'd0;
`endif
    end
    if (drop) begin
      state_d = IDLE;
      grant_d = 8'd0;
      idx_d   = 3'd0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 8'd0;
      idx_q   <= 3'd0;
      ptr_q   <= 3'd0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      to_q    <= to_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= 8'd0;
    else     hold_q <= hold_d;
  end
`endif

  assign arb.grant       = grant_q;
  assign arb.grant_idx   = idx_q;
  assign arb.grant_valid = valid_q;
`ifdef ARB_TIMEOUT_EN
  assign arb.timeout     = to_q;
`else
  assign arb.timeout     = 1'b0;
`endif
endmodule

// File: tb/tb_rr_arbiter8.sv
module tb_rr_arbiter8;
  logic clk, rst;
  rr_arbiter8_if bus();

  rr_arbiter8 #(.HOLD_MAX(4)) dut (.clk(clk), .rst(rst), .arb(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0] idx;
    logic       v;
    logic       to;
    string      name;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;

  task automatic cmp(input string nm, input logic [7:0] g, input logic [2:0] i,
                     input logic v, input logic t, input logic [2:0] ei,
                     input logic ev, input logic et);
    logic [7:0] eg;
    eg = ev ? (8'd1 << ei) : 8'd0;
    checks++;
    if ({g, i, v, t} === {eg, ei, ev, et}) passed++;
    else $display("FAIL %s: got grant=%h idx=%0d valid=%b timeout=%b, want grant=%h idx=%0d valid=%b timeout=%b",
                  nm, g, i, v, t, eg, ei, ev, et);
  endtask

  // Monitor: one expected response per clock edge while the queue is non-empty.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && q.size() > 0) begin
      e = q.pop_front();
      cmp(e.name, bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout, e.idx, e.v, e.to);
    end
  end

  // Drive req now and queue the response expected after the next edge.
  task automatic drive(input logic [7:0] r, input int idx, input logic v,
                       input logic to, input string nm);
    exp_t e;
    bus.req = r;
    e.idx = 3'(idx); e.v = v; e.to = to; e.name = nm;
    q.push_back(e);
  endtask

  task automatic step(input logic [7:0] r, input int idx, input logic v,
                      input logic to, input string nm);
    @(negedge clk);
    drive(r, idx, v, to, nm);
  endtask

  task automatic chk_zero(input string nm);
    cmp(nm, bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.req = 8'hFF;
    #1 chk_zero("reset_t0");
    repeat (3) @(negedge clk);
    chk_zero("reset_held");

    // First edge after release grants idx 0 (ptr=0).
    @(negedge clk);
    rst = 1'b0;
    drive(8'hFF, 0, 1'b1, 1'b0, "reset_first_grant");

    // Rotation: each holder drops for one cycle; handoff with no gap.
    for (int k = 0; k < 8; k++)
      step(~(8'd1 << k), (k + 1) % 8, 1'b1, 1'b0, $sformatf("rotate_%0d", k));
    step(8'h00, 0, 1'b0, 1'b0, "rotate_idle");          // ptr=1

    // Sparse with wrap from ptr=1.
    step(8'h81, 7, 1'b1, 1'b0, "sparse_7");             // ptr=0
    step(8'h01, 0, 1'b1, 1'b0, "sparse_wrap_0");        // ptr=1
    step(8'h00, 0, 1'b0, 1'b0, "sparse_idle");

    // Non-preemption: idx 3 holds while req[5] is up.
    step(8'h08, 3, 1'b1, 1'b0, "hold3_grant");          // ptr=4
    step(8'h28, 3, 1'b1, 1'b0, "hold3_keep_a");
    step(8'h28, 3, 1'b1, 1'b0, "hold3_keep_b");
    step(8'h20, 5, 1'b1, 1'b0, "hold3_handoff_5");      // ptr=6
    step(8'h00, 0, 1'b0, 1'b0, "hold_idle");

    // Async reset mid-grant while idx 4 holds.
    step(8'h10, 4, 1'b1, 1'b0, "async_grant4");         // scan 6,7,0..4
    step(8'h10, 4, 1'b1, 1'b0, "async_hold4");
    @(negedge clk);
    #2 rst = 1'b1;
    bus.req = 8'h00;
    #1 chk_zero("async_reset_drop");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step(8'hFF, 0, 1'b1, 1'b0, "post_reset_ptr0");      // ptr restarts at 0
    step(8'h00, 0, 1'b0, 1'b0, "post_reset_idle");

    // Reset again so the hold-limit section starts at ptr=0.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`ifdef ARB_TIMEOUT_EN
    step(8'h03, 0, 1'b1, 1'b0, "to_grant0");
    for (int k = 0; k < 3; k++) step(8'h03, 0, 1'b1, 1'b0, $sformatf("to_hold0_%0d", k));
    step(8'h03, 1, 1'b1, 1'b1, "to_move_1");
    for (int k = 0; k < 3; k++) step(8'h03, 1, 1'b1, 1'b0, $sformatf("to_hold1_%0d", k));
    step(8'h03, 0, 1'b1, 1'b1, "to_back_0");
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) step(8'h01, 0, 1'b1, 1'b0, $sformatf("to_solo_%0d_%0d", r, k));
      step(8'h01, 0, 1'b1, 1'b1, $sformatf("to_solo_pulse_%0d", r));
    end
    step(8'h00, 0, 1'b0, 1'b0, "to_idle");
`else
    step(8'h03, 0, 1'b1, 1'b0, "nto_grant0");
    for (int k = 0; k < 20; k++) step(8'h03, 0, 1'b1, 1'b0, $sformatf("nto_hold_%0d", k));
    step(8'h00, 0, 1'b0, 1'b0, "nto_idle");
`endif

    begin
      int budget;
      budget = 0;
      while (q.size() > 0 && budget < 50) begin
        @(negedge clk);
        budget++;
      end
      if (q.size() > 0) begin
        checks++;
        $display("FAIL drain: %0d expected responses left, want 0", q.size());
      end
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-way round-robin arbiter that shares one 3-to-8 decoded resource (one enable line per requester) among eight requesters. It grants exactly one requester at a time and drives both a one-hot grant vector and the equivalent 3-bit index. The index feeds the decoder select, and the one-hot vector is the decoder-compatible enable. The arbiter sits between requesting blocks and the shared decoded datapath, and is the only block that sequences that datapath.

## Interface
Parameters:
- HOLD_MAX, default 15: maximum consecutive grant cycles per holder when the timeout feature is compiled in. Legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector; bit i = requester i; level-sensitive, held high for as long as access is wanted.
- grant  output  8  one-hot grant, or all zero; bit i = requester i.
- grant_idx  output  3  binary index of the granted requester; 0 when none is granted.
- grant_valid  output  1  high while any grant bit is set.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked; tied 0 when the feature is compiled out.

## Operation
- One clock, clk. Reset rst is asynchronous and active-high. Reset clears all outputs and state immediately, without waiting for a clock edge: grant=8'h00, grant_idx=3'd0, grant_valid=0, timeout=0, ptr=3'd0, state IDLE, hold counter 0.
- State machine, two states:
  - IDLE, no grant:
    - req==0: stay in IDLE.
    - Otherwise: the winner is the first set bit of req scanning ptr, ptr+1, …, ptr+7 (mod 8). Register grant and grant_idx for the winner, go to GRANT, set ptr = winner+1 (mod 8).
  - GRANT, holder h:
    - req[h]==1: hold the grant.
    - req[h]==0: the holder has released. In the same edge, re-arbitrate over req from ptr; h is last in priority order.
      - Any request present: grant the new winner directly, with no idle gap.
      - None present: clear the grant and go to IDLE.
- ptr updates only when a new grant is issued.
- Requests from non-holders never preempt the holder.
- The outputs must always satisfy these invariants: grant is one-hot or zero; grant == (grant_valid ? 1<<grant_idx : 0).
- Indices wrap: after index 7 the scan continues at index 0.
- If a holder drops and re-raises req within the same cycle window, the arbiter sees only the sampled value at each edge. A sampled 0 counts as a release.

## Timing
- All outputs are registered, with no combinational path from req to any output.
- Grant latency: req first sampled high at edge k (arbiter in IDLE) → grant visible after edge k. That is one cycle from the request assertion.
- Release latency: req[h] sampled low at edge k → grant[h] low after edge k. Any handoff to the next winner happens at the same edge.
- Simultaneous requests at the same edge resolve purely by rotation order from ptr.
- Reset asserted mid-grant: grant drops asynchronously. Arbitration restarts from ptr=0 at the first edge after rst deasserts.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8-bit hold counter clears on each new grant and increments on each GRANT cycle in which req[h]==1.
  - When the count reaches HOLD_MAX with req[h] still high, the arbiter re-arbitrates excluding h from ptr and pulses timeout for one cycle.
  - If another requester is pending, the grant moves to that requester.
  - If none is pending, h keeps the grant and the counter restarts from 0. timeout still pulses.
- ARB_TIMEOUT_EN undefined: no hold counter; a holder may keep the grant indefinitely; timeout is constant 0.

## Test plan
- Reset check: apply rst=1 with req=8'hFF. Required: grant=0, grant_idx=0, grant_valid=0 throughout reset. After release, first edge → grant=8'h01, idx=0.
- Rotation: hold req=8'hFF and have each holder drop its req for one cycle after being granted. Required: grant sequence idx 0,1,2,…,7,0 with no idle cycle between grants.
- Sparse and wrap: req=8'h81 starting from ptr=1. Required: grant idx 7 first; after it releases, idx 0; then back to IDLE when req=0.
- Non-preemption: idx 3 is holding and req[5] rises. Required: grant stays 8'h08 until req[3] falls, then switches to 8'h20 at the same edge.
- Async reset mid-grant: assert rst between clock edges while grant=8'h10. Required: grant=0 before the next edge.
- Timeout (ARB_TIMEOUT_EN, HOLD_MAX=4): req=8'h03 held constant. Required: idx 0 holds for 4 cycles, timeout pulses, grant moves to idx 1; after 4 more cycles it returns to idx 0. With req=8'h01 only: the grant stays at idx 0 and timeout pulses every 4 cycles.
